// File: rtl/dmem_port_arbiter_if.sv
// Bundles the core, ext and data-memory signals of the data-memory port arbiter.
// master: requesters plus memory read data (environment side); slave: the arbiter.
interface dmem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic              core_rd;
    logic              core_wr;
    logic [2:0]        core_load_type;
    logic [1:0]        core_store_type;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_stall;

    logic              ext_valid;
    logic              ext_we;
    logic [2:0]        ext_load_type;
    logic [1:0]        ext_store_type;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ready;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;
    logic [15:0]       ext_grant_cnt;

    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_load_type;
    logic [1:0]        mem_store_type;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output core_rd, core_wr, core_load_type, core_store_type, core_addr, core_wdata,
        output ext_valid, ext_we, ext_load_type, ext_store_type, ext_addr, ext_wdata,
        output mem_rdata,
        input  core_rdata, core_stall, ext_ready, ext_rvalid, ext_rdata, ext_grant_cnt,
        input  mem_read, mem_write, mem_load_type, mem_store_type, mem_addr, mem_wdata
    );

    modport slave (
        input  core_rd, core_wr, core_load_type, core_store_type, core_addr, core_wdata,
        input  ext_valid, ext_we, ext_load_type, ext_store_type, ext_addr, ext_wdata,
        input  mem_rdata,
        output core_rdata, core_stall, ext_ready, ext_rvalid, ext_rdata, ext_grant_cnt,
        output mem_read, mem_write, mem_load_type, mem_store_type, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core has fixed priority with zero added latency; a
// starvation counter forces a single ext transfer after MAX_WAIT refused cycles.
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic [0:0] {CorePri, ExtForced} state_e;

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    state_e            state_q;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              ext_rvalid_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic [15:0]       grant_cnt_q;

    logic              core_req;
    logic              forced;
    logic              ext_ready;
    logic              core_gnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Grant decision; core_stall deliberately depends only on state and core_req.
    always_comb begin
        core_req  = bus.core_rd | bus.core_wr;
        forced    = (state_q == ExtForced);
        ext_ready = forced ? bus.ext_valid : (bus.ext_valid & ~core_req);
        core_gnt  = core_req & ~forced;
    end

    // Starvation counter next value: clear on accept or withdrawal, saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!bus.ext_valid || ext_ready) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q < MaxWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // Memory mux; with no grantee the address/data/types still carry the core values.
    always_comb begin
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.mem_load_type  = bus.core_load_type;
        bus.mem_store_type = bus.core_store_type;
        addr_mux           = bus.core_addr;
        wdata_mux          = bus.core_wdata;
        if (ext_ready) begin
            bus.mem_read       = ~bus.ext_we;
            bus.mem_write      = bus.ext_we;
            bus.mem_load_type  = bus.ext_load_type;
            bus.mem_store_type = bus.ext_store_type;
            addr_mux           = bus.ext_addr;
            wdata_mux          = bus.ext_wdata;
        end else if (core_gnt) begin
            // Store wins if both are raised.
            bus.mem_read  = bus.core_rd & ~bus.core_wr;
            bus.mem_write = bus.core_wr;
        end
    end

    assign bus.mem_addr      = addr_mux;
    assign bus.mem_wdata     = wdata_mux;
    assign bus.core_rdata    = bus.mem_rdata;
    assign bus.core_stall    = forced & core_req;
    assign bus.ext_ready     = ext_ready;
    assign bus.ext_rvalid    = ext_rvalid_q;
    assign bus.ext_rdata     = ext_rdata_q;
    assign bus.ext_grant_cnt = grant_cnt_q;

    // Arbitration FSM: a forced grant lasts one accept (or ends on withdrawal).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= CorePri;
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            unique case (state_q)
                CorePri: if (wait_cnt_d == MaxWait) state_q <= ExtForced;
                ExtForced: if (ext_ready || !bus.ext_valid) state_q <= CorePri;
                default: state_q <= CorePri;
            endcase
        end
    end

    // Ext load response and accept counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
            grant_cnt_q  <= 16'd0;
        end else begin
            ext_rvalid_q <= ext_ready & ~bus.ext_we;
            if (ext_ready && !bus.ext_we) begin
                ext_rdata_q <= bus.mem_rdata;
            end
            if (ext_ready) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
        end
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between the pipeline MEM stage (core port) and an external loader/debug requester (ext port). The core has fixed priority and sees zero added latency when it owns the port. A starvation counter forces one ext transfer after `MAX_WAIT` refused cycles, stalling the core for exactly that cycle. It sits between the MEM stage and `data_mem_top`, and drives that memory's control, address and store-data inputs.

## Interface

**Parameters**
- `ADDR_W`, default 10: data-memory byte-address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 8: refused ext cycles before a forced ext grant. Legal range 1..255.

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `core_rd` in 1: MEM-stage load request.
- `core_wr` in 1: MEM-stage store request.
- `core_load_type` in 3: load type, passed to memory.
- `core_store_type` in 2: store type, passed to memory.
- `core_addr` in `ADDR_W`: core address.
- `core_wdata` in `DATA_W`: core store data.
- `core_rdata` out `DATA_W`: combinational read data to the MEM stage.
- `core_stall` out 1: the core access was not performed this cycle; the pipeline holds EX/MEM.
- `ext_valid` in 1: ext request valid.
- `ext_we` in 1: 1 = store, 0 = load.
- `ext_load_type` in 3: ext load type.
- `ext_store_type` in 2: ext store type.
- `ext_addr` in `ADDR_W`: ext address.
- `ext_wdata` in `DATA_W`: ext store data.
- `ext_ready` out 1: ext request accepted this cycle.
- `ext_rvalid` out 1: registered; ext load data valid.
- `ext_rdata` out `DATA_W`: registered ext load data.
- `ext_grant_cnt` out 16: count of accepted ext transfers; wraps.
- `mem_read` out 1: to data memory.
- `mem_write` out 1: to data memory.
- `mem_load_type` out 3: to data memory.
- `mem_store_type` out 2: to data memory.
- `mem_addr` out `ADDR_W`: to data memory.
- `mem_wdata` out `DATA_W`: to data memory.
- `mem_rdata` in `DATA_W`: combinational read data from memory.

## Operation

**Core request**
- `core_req = core_rd | core_wr`.
- Both `core_rd` and `core_wr` high together is illegal; `core_wr` wins.

**State machine** (`state`: `CORE_PRI`, `EXT_FORCED`; reset → `CORE_PRI`)
- In `CORE_PRI`:
  - `ext_ready = ext_valid & ~core_req`.
  - The core is granted whenever `core_req` is high.
- In `EXT_FORCED`:
  - `ext_ready = ext_valid`.
  - `core_stall = core_req`.
  - The ext request is granted.

**Starvation counter** (`wait_cnt`, 8 bits)
- Increments on cycles with `ext_valid & ~ext_ready`, saturating at `MAX_WAIT`.
- Clears on an accept, or on any cycle where `ext_valid` is 0 (ext withdrew).

**Transitions**
- `CORE_PRI` → `EXT_FORCED` when the next value of `wait_cnt` equals `MAX_WAIT`.
- `EXT_FORCED` → `CORE_PRI` after one ext accept, or when `ext_valid` falls.
- A forced grant therefore covers exactly one transfer. The core regains priority the following cycle.

**Memory mux**
- When the grantee is the core: `mem_*` is driven from `core_*`, with `mem_read = core_rd & ~core_wr`.
- When the grantee is ext: `mem_read = ~ext_we` and `mem_write = ext_we`.
- When there is no grantee: `mem_read = mem_write = 0`, and address/data hold the core values.
- `core_rdata = mem_rdata` always. Its value is meaningful only when the core is granted for a load.

**Ext handshake**
- `ext_valid` and the ext payload must stay stable until `ext_ready`.
- `ext_ready` is high only while `ext_valid` is high.

**Ext response**
- On an accepted ext load: `ext_rdata <= mem_rdata` and `ext_rvalid <= 1` for exactly one cycle.
- Ext stores produce no `ext_rvalid`.
- Ext has no response backpressure.

**Grant counter**
- `ext_grant_cnt` increments on each accept, and wraps from 0xFFFF to 0.

## Timing
- Reset values: `state = CORE_PRI`, `wait_cnt = 0`, `ext_rvalid = 0`, `ext_rdata = 0`, `ext_grant_cnt = 0`.
- While in reset, the combinational outputs follow the `CORE_PRI` rules.
- Core access:
  - 0-cycle added latency.
  - `core_stall` is combinational, but depends only on `state` and `core_req`.
  - `core_stall` has no path from `ext_*`.
- Ext load: accept in cycle N, `ext_rvalid` and `ext_rdata` in cycle N+1.
- Worst-case ext wait under continuous core traffic is `MAX_WAIT` refused cycles, then accept on the next cycle.
- The forced stall lasts exactly 1 cycle per forced transfer.
- Reset asserted mid-operation: any pending `ext_rvalid` is dropped, the counter clears, and the state returns to `CORE_PRI`. No partial write occurs, because writes are single-cycle.

## Test plan
- **Idle core.** Ext load, addr 0x010, memory holding 0xDEADBEEF → `ext_ready` in the same cycle; next cycle `ext_rvalid` = 1 and `ext_rdata` = 0xDEADBEEF; `ext_grant_cnt` = 1.
- **Continuous core traffic, default `MAX_WAIT` = 8.** `core_rd` high every cycle, ext store held valid → `ext_ready` stays 0 for 8 cycles. On cycle 9, `ext_ready` = 1, `core_stall` = 1 and `mem_write` = 1 with the ext address. On cycle 10, `core_stall` = 0 and the core is granted.
- **Withdrawal.** Ext valid for 5 cycles under core traffic, then `ext_valid` drops for 1 cycle, then reasserts → counter restarts from 0; the forced grant occurs 8 refused cycles after the reassert.
- **Core store vs core load.** Core store of 0x12345678 to 0x020, then core load from 0x020 → `core_rdata` = 0x12345678 in the load cycle; `core_stall` never asserts.
- **Grant counter wrap.** Preload by 65535 ext accepts, then one more → `ext_grant_cnt` wraps to 0.
- **Reset mid-operation.** Assert `rst` = 0 in the cycle after an ext load accept → `ext_rvalid` = 0, `state` = `CORE_PRI`, `wait_cnt` = 0 immediately. After release, the core is granted with no stall.
